// File: rtl/seven_seg_scanner.sv
// Multiplexed hex seven-segment scanner: one digit lit at a time, with a
// double-buffered display value that is swapped only at frame boundaries.
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_blank_leading,
  output logic [7:0]              o_seven_seg,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_done,
  output logic                    o_pending_valid
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]                 r_presc;
  logic [IW-1:0]                 r_idx;
  logic [4*NUM_DIGITS-1:0]       r_disp;
  logic [4*NUM_DIGITS-1:0]       r_pend;
  logic                          r_pend_vld;

  logic                          w_tick;
  logic                          w_frame;
  logic [NUM_DIGITS-1:0][3:0]    w_digit;
  logic [NUM_DIGITS-1:0]         w_lead_zero;
  logic                          w_blank;
  logic [7:0]                    w_seg;
  logic [NUM_DIGITS-1:0]         w_sel;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0111111;
      4'h1: seg7 = 7'b0000110;
      4'h2: seg7 = 7'b1011011;
      4'h3: seg7 = 7'b1001111;
      4'h4: seg7 = 7'b1100110;
      4'h5: seg7 = 7'b1101101;
      4'h6: seg7 = 7'b1111101;
      4'h7: seg7 = 7'b0000111;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1101111;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b1111100;
      4'hC: seg7 = 7'b0111001;
      4'hD: seg7 = 7'b1011110;
      4'hE: seg7 = 7'b1111001;
      default: seg7 = 7'b1110001;
    endcase
  endfunction

  assign w_tick  = (r_presc == PS_LAST);
  // Masked during reset so no spurious frame pulse leaks out of a reset cycle.
  assign w_frame = w_tick && (r_idx == IDX_LAST) && !i_rst;

  // Digit 0 is the most significant nibble; lead_zero[k] means digits 0..k are all zero.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign w_digit[k]     = r_disp[4*(NUM_DIGITS-1-k) +: 4];
    assign w_lead_zero[k] = (r_disp[4*NUM_DIGITS-1 -: 4*(k+1)] == '0);
  end

  assign w_blank = i_blank_leading && (r_idx != IDX_LAST) && w_lead_zero[r_idx];
  assign w_seg   = w_blank ? 8'h00 : {1'b0, seg7(w_digit[r_idx])};

  always_comb begin
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
  end

  assign o_seven_seg     = ACTIVE_LOW ? ~w_seg : w_seg;
  assign o_digit_sel     = ACTIVE_LOW ? ~w_sel : w_sel;
  assign o_frame_done    = w_frame;
  assign o_pending_valid = r_pend_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_disp     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      // Swap only at the frame boundary so a frame never mixes two values.
      if (w_frame && r_pend_vld)
        r_disp <= r_pend;
      if (i_load) begin
        r_pend     <= i_value;
        r_pend_vld <= 1'b1;
      end else if (w_frame) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of hex digits displayed; legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles each digit is held before the scan advances; legal range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 0: when 1, SevenSeg and DigitSel are bitwise inverted at the output.
REQ-004 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Rst  input  1  synchronous reset, active-high, sampled on the rising edge of Clk.
REQ-006 Value  input  4*NUM_DIGITS  hex value to display; nibble [4*NUM_DIGITS-1 -: 4] is digit 0 (most significant).
REQ-007 Load  input  1  when high, Value is captured into the pending register on that edge.
REQ-008 BlankLeading  input  1  when high, leading-zero digits are blanked.
REQ-009 SevenSeg  output  8  segment pattern for the selected digit; bit0=a to bit6=g, bit7=dp, always 0 (before inversion).
REQ-010 DigitSel  output  NUM_DIGITS  one-hot digit enable; bit k selects digit k.
REQ-011 FrameDone  output  1  single-cycle pulse in the last cycle of each full scan frame.
REQ-012 PendingValid  output  1  high while a loaded value waits for transfer to the display register.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (prescaler == SCAN_DIV-1).
REQ-014 Digit index counts 0..NUM_DIGITS-1 and advances by one on each tick, wrapping from NUM_DIGITS-1 to 0.
REQ-015 DigitSel shall be combinational from the digit index: bit [index] high, all other bits low.
REQ-016 FrameDone = tick AND (index == NUM_DIGITS-1), combinational.
REQ-017 Load high: pending register <= Value and PendingValid <= 1 on that edge; repeated loads overwrite, and only the last one is kept.
REQ-018 On a FrameDone edge with PendingValid=1 (value before the edge): display register <= pending register contents from before the edge; PendingValid <= 0 unless Load is also high on the same edge.
REQ-019 Load and FrameDone on the same edge: the old pending value goes to the display, the new Value goes to pending, and PendingValid stays 1 (no tearing within a frame).
REQ-020 The display register changes only on FrameDone edges.
REQ-021 SevenSeg shall be combinational from the display-register nibble selected by index, using this encoding:
  0=00111111, 1=00000110, 2=01011011, 3=01001111, 4=01100110, 5=01101101, 6=01111101, 7=00000111,
  8=01111111, 9=01101111, A=01110111, b=01111100, C=00111001, d=01011110, E=01111001, F=01110001.
REQ-022 Leading-zero blanking: with BlankLeading=1, SevenSeg=00000000 for digit k < NUM_DIGITS-1 when nibbles 0..k are all zero.
REQ-023 The least-significant digit is never blanked.
REQ-024 DigitSel keeps scanning while digits are blanked.
REQ-025 BlankLeading is a live, unregistered input and takes effect in the same cycle.
REQ-026 ACTIVE_LOW inversion shall apply after blanking, so a blanked digit reads 11111111 when ACTIVE_LOW=1.

Reset
REQ-027 On Rst: prescaler=0, index=0, display register=0, pending register=0, PendingValid=0.
REQ-028 Rst has priority over Load.
REQ-029 While in reset (ACTIVE_LOW=0): DigitSel=1 at bit0, FrameDone=0, SevenSeg=00111111 (BlankLeading=0) or 00000000 (BlankLeading=1).
REQ-030 Rst asserted mid-frame shall abandon the frame and discard any pending value.

Verification (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0)
REQ-031 Reset -> DigitSel=0001, SevenSeg=00111111, PendingValid=0, FrameDone=0; DigitSel advances every 4 cycles, and FrameDone pulses on cycle 16.
REQ-032 Load with Value=16'h0013 -> PendingValid=1 until the next FrameDone edge; the next frame shows digits 0..3 = 00111111, 00111111, 00000110, 01001111.
REQ-033 Same as REQ-032 with BlankLeading=1 -> digits 0..3 = 00000000, 00000000, 00000110, 01001111.
REQ-034 Value=16'hABCD loaded -> next frame shows 01110111, 01111100, 00111001, 01011110.
REQ-035 Display 16'h1234, Load 16'h5678 on the FrameDone cycle -> next frame still shows 1234 and PendingValid=1; the following frame shows 5678 and PendingValid=0.
REQ-036 Loads of 16'h1111 then 16'h2222 in one frame, Rst mid-next-frame -> the 2222 frame is displayed once, then all state returns to reset values and the display shows 0000.
